// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between requester A (CPU
// load/store) and requester B (debug/DMA). One access is in flight at a time.
// A has fixed priority. B is forced to win after MAX_WAIT consecutive A grants
// made while B was pending.
//
// Ports:
//   clk, rst_n                     clock (rising edge), async active-low reset
//   a_req/a_we/a_addr/a_wdata      requester A request; held until a_gnt
//   a_gnt                          combinational grant pulse (IDLE only)
//   a_rvalid/a_rdata               A read response, one cycle after ACCESS
//   b_*                            same set of ports for requester B
//   mem_we/mem_addr/mem_wdata      registered memory command, valid in ACCESS
//   mem_rdata                      memory read data, valid the cycle after mem_addr
//   addr_err                       pulses in ACCESS for an out-of-range access
module dmem_arbiter #(
    parameter int unsigned AWIDTH   = 32,
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned ALENGTH  = 128,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [AWIDTH-1:0] a_addr,
    input  logic [DWIDTH-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DWIDTH-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [AWIDTH-1:0] b_addr,
    input  logic [DWIDTH-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DWIDTH-1:0] b_rdata,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              addr_err
);

    localparam int unsigned       WCW    = 4;
    localparam logic [WCW-1:0]    WMAX   = WCW'(MAX_WAIT);
    localparam logic [AWIDTH-1:0] ALIMIT = AWIDTH'(ALENGTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WCW-1:0]    wait_cnt;
    logic              owner_b;      // 0: A owns the access, 1: B owns it
    logic              lat_we;
    logic              lat_err;
    logic [DWIDTH-1:0] a_rdata_q;
    logic [DWIDTH-1:0] b_rdata_q;

    logic              sel_we;
    logic [AWIDTH-1:0] sel_addr;
    logic [DWIDTH-1:0] sel_wdata;
    logic              sel_oor;
    logic [DWIDTH-1:0] resp_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and combinational grants
    always_comb begin
        state_nxt = state;
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        case (state)
            S_IDLE: begin
                if (rst_n && b_req && ((wait_cnt == WMAX) || !a_req)) begin
                    b_gnt     = 1'b1;
                    state_nxt = S_ACCESS;
                end else if (rst_n && a_req) begin
                    a_gnt     = 1'b1;
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: state_nxt = lat_we ? S_IDLE : S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Winner's request fields
    assign sel_we    = b_gnt ? b_we    : a_we;
    assign sel_addr  = b_gnt ? b_addr  : a_addr;
    assign sel_wdata = b_gnt ? b_wdata : a_wdata;
    assign sel_oor   = (sel_addr >= ALIMIT);

    // Out-of-range reads return zero instead of whatever the memory aliases to
    assign resp_data = lat_err ? '0 : mem_rdata;

    // Read data passes through in RESP (memory data only exists then), else holds
    assign a_rdata = ((state == S_RESP) && !owner_b) ? resp_data : a_rdata_q;
    assign b_rdata = ((state == S_RESP) &&  owner_b) ? resp_data : b_rdata_q;

    // Access latches, memory command, responses and starvation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            owner_b   <= 1'b0;
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            addr_err  <= 1'b0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            mem_we   <= 1'b0;
            addr_err <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;

            if (a_gnt || b_gnt) begin
                owner_b   <= b_gnt;
                lat_we    <= sel_we;
                lat_err   <= sel_oor;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                mem_we    <= sel_we && !sel_oor;
                addr_err  <= sel_oor;
            end

            if (b_gnt) begin
                wait_cnt <= '0;
            end else if (a_gnt && b_req && (wait_cnt != WMAX)) begin
                wait_cnt <= wait_cnt + WCW'(1);
            end

            if ((state == S_ACCESS) && !lat_we) begin
                a_rvalid <= !owner_b;
                b_rvalid <= owner_b;
            end

            if (state == S_RESP) begin
                if (owner_b) begin
                    b_rdata_q <= resp_data;
                end else begin
                    a_rdata_q <= resp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a synchronous-read memory model.
module tb_dmem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned AL = 128;
    localparam int unsigned MW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_we, addr_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] mem [0:AL-1];
    int n_chk  = 0;
    int n_pass = 0;

    dmem_arbiter #(
        .AWIDTH(AW), .DWIDTH(DW), .ALENGTH(AL), .MAX_WAIT(MW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Single-port RAM: write on mem_we, read data registered one cycle later
    always @(posedge clk) begin
        if (mem_we && (mem_addr < AW'(AL))) mem[mem_addr[6:0]] <= mem_wdata;
        mem_rdata <= (mem_addr < AW'(AL)) ? mem[mem_addr[6:0]] : 32'hBAD0_0000;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k, rk;
        bit  g, bw, rv, rb;

        for (int i = 0; i < int'(AL); i++) mem[i] = 32'hA000_0000 + 32'(i);
        rst_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_a_gnt",    64'(a_gnt),     64'd0);
        check("rst_b_gnt",    64'(b_gnt),     64'd0);
        check("rst_a_rvalid", 64'(a_rvalid),  64'd0);
        check("rst_b_rvalid", 64'(b_rvalid),  64'd0);
        check("rst_mem_we",   64'(mem_we),    64'd0);
        check("rst_addr_err", 64'(addr_err),  64'd0);
        check("rst_mem_addr", 64'(mem_addr),  64'd0);
        check("rst_mem_wdat", 64'(mem_wdata), 64'd0);
        check("rst_a_rdata",  64'(a_rdata),   64'd0);
        check("rst_b_rdata",  64'(b_rdata),   64'd0);
        @(negedge clk); rst_n = 1'b1;

        // A writes 0xDEADBEEF to 5, then reads it back
        @(negedge clk); a_req = 1'b1; a_we = 1'b1; a_addr = 32'd5; a_wdata = 32'hDEAD_BEEF; #1;
        check("wr_a_gnt",     64'(a_gnt),  64'd1);
        check("wr_pre_memwe", 64'(mem_we), 64'd0);
        @(negedge clk); a_req = 1'b0; #1;
        check("wr_acc_gnt",   64'(a_gnt),     64'd0);
        check("wr_acc_memwe", 64'(mem_we),    64'd1);
        check("wr_acc_addr",  64'(mem_addr),  64'd5);
        check("wr_acc_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        check("wr_acc_err",   64'(addr_err),  64'd0);
        @(negedge clk); a_req = 1'b1; a_we = 1'b0; #1;
        check("rd_a_gnt",     64'(a_gnt),  64'd1);
        check("rd_memwe_off", 64'(mem_we), 64'd0);
        @(negedge clk); a_req = 1'b0; #1;
        check("rd_acc_rvld",  64'(a_rvalid), 64'd0);
        check("rd_acc_memwe", 64'(mem_we),   64'd0);
        @(negedge clk); #1;
        check("rd_rsp_rvld",  64'(a_rvalid), 64'd1);
        check("rd_rsp_data",  64'(a_rdata),  64'hDEAD_BEEF);
        check("rd_rsp_brvld", 64'(b_rvalid), 64'd0);
        @(negedge clk); #1;
        check("rd_post_rvld", 64'(a_rvalid), 64'd0);
        check("rd_hold_data", 64'(a_rdata),  64'hDEAD_BEEF);

        // Reset in ACCESS of an A write (B pending bumps the starvation count)
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'd6; a_wdata = 32'h5555_5555;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'd20; #1;
        check("mrw_a_gnt", 64'(a_gnt), 64'd1);
        check("mrw_b_gnt", 64'(b_gnt), 64'd0);
        @(negedge clk); a_req = 1'b0; b_req = 1'b0; #1;
        check("mrw_memwe_on", 64'(mem_we), 64'd1);
        rst_n = 1'b0; #1;
        check("mrw_memwe_async", 64'(mem_we), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Reset in ACCESS of an A read
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd5; b_req = 1'b1; #1;
        check("mrr_a_gnt", 64'(a_gnt), 64'd1);
        @(negedge clk); a_req = 1'b0; b_req = 1'b0; #1;
        rst_n = 1'b0; #1;
        check("mrr_memwe",  64'(mem_we),   64'd0);
        check("mrr_rvld0",  64'(a_rvalid), 64'd0);
        @(negedge clk); #1;
        check("mrr_rvld1",  64'(a_rvalid), 64'd0);
        @(negedge clk); #1;
        check("mrr_rvld2",  64'(a_rvalid), 64'd0);
        check("mrr_rdata",  64'(a_rdata),  64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Contention: both held; grants every 3 cycles, B wins the 5th and 10th
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (c == 0) begin
                a_req = 1'b1; a_we = 1'b0; a_addr = 32'd10;
                b_req = 1'b1; b_we = 1'b0; b_addr = 32'd20;
            end
            if (c == 28) begin a_req = 1'b0; b_req = 1'b0; end
            #1;
            k  = c / 3;
            g  = (c % 3 == 0) && (k < 10);
            bw = (k == 4) || (k == 9);
            rv = (c % 3 == 2) && (c <= 29);
            rk = (c - 2) / 3;
            rb = (rk == 4) || (rk == 9);
            check($sformatf("cont_a_gnt_c%0d", c),    64'(a_gnt),    64'(g && !bw));
            check($sformatf("cont_b_gnt_c%0d", c),    64'(b_gnt),    64'(g && bw));
            check($sformatf("cont_a_rvalid_c%0d", c), 64'(a_rvalid), 64'(rv && !rb));
            check($sformatf("cont_b_rvalid_c%0d", c), 64'(b_rvalid), 64'(rv && rb));
            if (rv && !rb) check($sformatf("cont_a_rdata_c%0d", c), 64'(a_rdata), 64'hA000_000A);
            if (rv && rb)  check($sformatf("cont_b_rdata_c%0d", c), 64'(b_rdata), 64'hA000_0014);
        end

        // Out of range: B reads 128, then writes 200
        @(negedge clk); b_req = 1'b1; b_we = 1'b0; b_addr = 32'd128; #1;
        check("oor_rd_gnt",   64'(b_gnt),    64'd1);
        @(negedge clk); b_req = 1'b0; #1;
        check("oor_rd_err",   64'(addr_err), 64'd1);
        check("oor_rd_memwe", 64'(mem_we),   64'd0);
        check("oor_rd_addr",  64'(mem_addr), 64'd128);
        @(negedge clk); #1;
        check("oor_rd_rvld",  64'(b_rvalid), 64'd1);
        check("oor_rd_data",  64'(b_rdata),  64'd0);
        check("oor_rd_arvld", 64'(a_rvalid), 64'd0);
        check("oor_rd_err_off", 64'(addr_err), 64'd0);
        @(negedge clk); b_req = 1'b1; b_we = 1'b1; b_addr = 32'd200; b_wdata = 32'hFFFF_FFFF; #1;
        check("oor_wr_gnt",   64'(b_gnt),    64'd1);
        check("oor_wr_rvld",  64'(b_rvalid), 64'd0);
        @(negedge clk); b_req = 1'b0; #1;
        check("oor_wr_err",   64'(addr_err), 64'd1);
        check("oor_wr_memwe", 64'(mem_we),   64'd0);
        @(negedge clk); #1;
        check("oor_wr_err_off", 64'(addr_err), 64'd0);
        check("oor_wr_memwe2",  64'(mem_we),   64'd0);
        check("oor_wr_brvld",   64'(b_rvalid), 64'd0);

        // Back-to-back A reads: grants 3 cycles apart
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin a_req = 1'b1; a_we = 1'b0; a_addr = 32'd7; end
            if (c == 7) a_req = 1'b0;
            #1;
            check($sformatf("rdb2b_gnt_c%0d", c),  64'(a_gnt),    64'((c % 3 == 0) && (c <= 6)));
            check($sformatf("rdb2b_rvld_c%0d", c), 64'(a_rvalid), 64'((c % 3 == 2) && (c <= 8)));
        end

        // Back-to-back A writes: grants 2 cycles apart
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 0) begin a_req = 1'b1; a_we = 1'b1; a_addr = 32'd40; a_wdata = 32'h0BAD_CAFE; end
            if (c == 7) a_req = 1'b0;
            #1;
            check($sformatf("wrb2b_gnt_c%0d", c),   64'(a_gnt),  64'((c % 2 == 0) && (c <= 6)));
            check($sformatf("wrb2b_memwe_c%0d", c), 64'(mem_we), 64'(c % 2 == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
